updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
Parametrised up/down counter, successor to the fixed 4-bit up/down counter.
- Adds configurable width, a run-time modulus (max_val), synchronous parallel load, count enable, and a wrap or saturate mode.
- Adds registered terminal-count and saturation flags.
- Used as a general timer/index counter in the control datapath.

Parameters:
WIDTH, 8, counter width in bits (>=2)
SAT_MODE, 0, 0 = wrap at bounds, 1 = saturate (hold) at bounds
RESET_VAL, 0, count value after reset (must be <= 2^WIDTH-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; count advances only when high
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
max_val  input  WIDTH  upper bound of count range [0, max_val]; sampled every cycle
count  output  WIDTH  registered counter value
tc  output  1  registered one-cycle pulse: a wrap occurred this cycle (count just wrapped)
sat  output  1  registered level: the last enabled step was blocked by a bound (SAT_MODE=1 only)
at_max  output  1  combinational: count == max_val
at_zero  output  1  combinational: count == 0

Behaviour:
Interface
- One clock, clk.
- reset is synchronous and active-high.
- All state updates on rising clk only.

Reset
- count=RESET_VAL, tc=0, sat=0.
- Applies on any cycle, including mid-load or mid-count.

Priority
- reset > load > en. When en=0 and load=0, count holds.

Load
- count <= min(load_val, max_val). tc=0. sat=0.
- Ignores en and up_down.

Up step (en=1, up_down=1)
- count < max_val: count+1, tc=0, sat=0.
- count >= max_val, SAT_MODE=0: count <= 0, tc=1.
- count >= max_val, SAT_MODE=1: count <= max_val, tc=0, sat=1.

Down step (en=1, up_down=0)
- count == 0, SAT_MODE=0: count <= max_val, tc=1.
- count == 0, SAT_MODE=1: count holds 0, tc=0, sat=1.
- count > max_val (max_val lowered at run time): count <= max_val, tc=0, sat=0.
- Otherwise: count-1, tc=0, sat=0.

Flags
- tc is high for exactly one cycle, coincident with the wrapped count value on the output; it is low on any cycle without a wrap.
- sat stays high while blocked steps continue.
  - Clears on the first successful step, on load, or on reset.
  - On en=0 it holds its previous value.
- SAT_MODE=0: sat is tied 0.

Arithmetic and latency
- All arithmetic is unsigned at WIDTH bits; no carry out beyond WIDTH.
- Latency: one cycle from input to count, tc and sat.
- at_max and at_zero have zero latency relative to count.

Edge cases
- max_val=0: count pinned to 0.
  - Wrap mode: every enabled step pulses tc.
  - Saturate mode: every enabled step sets sat.
- max_val changing while counting takes effect on the next step decision; no glitch on count.
- up_down change takes effect on the same enabled edge.

Decomposition:
- Shared package counter_pkg holds:
  - localparams CNT_MODE_WRAP=0 and CNT_MODE_SAT=1;
  - a function clamp_to_max(value, max), reused by other counters.
- No sub-module: next-state logic is a single combinational block feeding one register bank.
- Estimated 150-200 lines of RTL.

Test Plan:
- Reset and count up: WIDTH=4, SAT_MODE=0, max_val=9. Assert reset, then en=1, up_down=1 for 10 cycles -> count 0..9, then 0 with tc=1 exactly on that cycle.
- Wrap down: max_val=9, count=0, en=1, up_down=0 -> count=9 and tc=1 next cycle; following cycle count=8, tc=0.
- Saturate up: SAT_MODE=1, max_val=5, load_val=4 loaded, then up 3 cycles -> count 5,5,5; sat=1 from the second step. Then one down step -> count=4, sat=0.
- Load clamp and priority: max_val=7, load=1, load_val=12, en=1 in the same cycle -> count=7, no increment. Then reset=1 with load=1 -> count=RESET_VAL.
- Run-time max shrink: count=8, max_val changed to 3. Up step -> count=0 with tc=1 (wrap mode) or count=3 (saturate mode). Down step from 8 -> count=3.
- Enable hold and max_val=0: en=0 for 5 cycles -> count unchanged, tc=0. Then max_val=0, en=1, up -> count=0 and tc=1 every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter mode constants and helpers
package counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Wide operands so counters of any width up to 64 bits can reuse this.
    function automatic logic [63:0] clamp_to_max(input logic [63:0] value,
                                                 input logic [63:0] max_lim);
        return (value > max_lim) ? max_lim : value;
    endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with load, wrap or saturate mode
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SAT_MODE  = CNT_MODE_WRAP,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             sat_nxt;

    always_comb begin
        cnt_nxt = count;
        tc_nxt  = 1'b0;
        sat_nxt = sat;
        if (load) begin
            cnt_nxt = WIDTH'(clamp_to_max(64'(load_val), 64'(max_val)));
            sat_nxt = 1'b0;
        end else if (en) begin
            if (up_down) begin
                // count above max_val (max lowered at run time) is treated as at the bound
                if (count < max_val) begin
                    cnt_nxt = count + WIDTH'(1);
                    sat_nxt = 1'b0;
                end else if (SAT_MODE == CNT_MODE_SAT) begin
                    cnt_nxt = max_val;
                    sat_nxt = 1'b1;
                end else begin
                    cnt_nxt = '0;
                    tc_nxt  = 1'b1;
                end
            end else begin
                if (count == '0) begin
                    if (SAT_MODE == CNT_MODE_SAT) begin
                        sat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = max_val;
                        tc_nxt  = 1'b1;
                    end
                end else if (count > max_val) begin
                    cnt_nxt = max_val;
                    sat_nxt = 1'b0;
                end else begin
                    cnt_nxt = count - WIDTH'(1);
                    sat_nxt = 1'b0;
                end
            end
        end
        if (SAT_MODE != CNT_MODE_SAT) begin
            sat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VAL;
            tc    <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= cnt_nxt;
            tc    <= tc_nxt;
            sat   <= sat_nxt;
        end
    end

    assign at_max  = (count == max_val);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - randomized check of wrap and saturate counters against a model
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_down, load;
    logic [3:0] load_val, max_val;

    logic [3:0] cnt_w, cnt_s;
    logic       tc_w, tc_s, sat_w, sat_s, amax_w, amax_s, azero_w, azero_s;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt [2];
    int m_tc  [2];
    int m_sat [2];
    int rst_val [2] = '{0, 2};

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .SAT_MODE(0), .RESET_VAL(4'd0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .count(cnt_w), .tc(tc_w),
        .sat(sat_w), .at_max(amax_w), .at_zero(azero_w)
    );

    updown_mod_counter #(.WIDTH(4), .SAT_MODE(1), .RESET_VAL(4'd2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .count(cnt_s), .tc(tc_s),
        .sat(sat_s), .at_max(amax_s), .at_zero(azero_s)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: range [0,m] treated as a ring of m+1 values; saturation blocks at the ends.
    task automatic model_step(input int i);
        int c, m;
        bit sat_mode;
        c = m_cnt[i];
        m = int'(max_val);
        sat_mode = (i == 1);
        m_tc[i] = 0;
        if (reset) begin
            m_cnt[i] = rst_val[i];
            m_sat[i] = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) < m) ? int'(load_val) : m;
            m_sat[i] = 0;
        end else if (en) begin
            if (up_down) begin
                if (c < m) begin
                    m_cnt[i] = c + 1;
                    m_sat[i] = 0;
                end else if (sat_mode) begin
                    m_cnt[i] = m;
                    m_sat[i] = 1;
                end else begin
                    m_cnt[i] = 0;
                    m_tc[i]  = 1;
                end
            end else begin
                if (c == 0) begin
                    if (sat_mode) m_sat[i] = 1;
                    else begin
                        m_cnt[i] = (c + m) % (m + 1);
                        m_tc[i]  = 1;
                    end
                end else begin
                    m_cnt[i] = (c > m) ? m : c - 1;
                    m_sat[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk_eq("wrap.count",  32'(cnt_w),   32'(m_cnt[0]));
        chk_eq("wrap.tc",     32'(tc_w),    32'(m_tc[0]));
        chk_eq("wrap.sat",    32'(sat_w),   32'(m_sat[0]));
        chk_eq("wrap.at_max", 32'(amax_w),  32'(m_cnt[0] == int'(max_val)));
        chk_eq("wrap.at_zero",32'(azero_w), 32'(m_cnt[0] == 0));
        chk_eq("sat.count",   32'(cnt_s),   32'(m_cnt[1]));
        chk_eq("sat.tc",      32'(tc_s),    32'(m_tc[1]));
        chk_eq("sat.sat",     32'(sat_s),   32'(m_sat[1]));
        chk_eq("sat.at_max",  32'(amax_s),  32'(m_cnt[1] == int'(max_val)));
        chk_eq("sat.at_zero", 32'(azero_s), 32'(m_cnt[1] == 0));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0;
        load_val = 4'd0; max_val = 4'd9;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_sat[i] = 0;
        end
        tick();
        chk_eq("reset.wrap_count", 32'(cnt_w), 32'd0);
        chk_eq("reset.sat_count",  32'(cnt_s), 32'd2);

        // count up through the wrap
        reset = 1'b0; en = 1'b1; up_down = 1'b1;
        repeat (10) tick();
        chk_eq("upwrap.count", 32'(cnt_w), 32'd0);
        chk_eq("upwrap.tc",    32'(tc_w),  32'd1);

        // wrap down from zero
        up_down = 1'b0;
        tick();
        chk_eq("dnwrap.count", 32'(cnt_w), 32'd9);
        chk_eq("dnwrap.tc",    32'(tc_w),  32'd1);
        tick();
        chk_eq("dnwrap.next",  32'(cnt_w), 32'd8);

        // saturate up then step down
        max_val = 4'd5; load_val = 4'd4; load = 1'b1;
        tick();
        load = 1'b0; up_down = 1'b1;
        repeat (3) tick();
        chk_eq("satup.count", 32'(cnt_s), 32'd5);
        chk_eq("satup.sat",   32'(sat_s), 32'd1);
        up_down = 1'b0;
        tick();
        chk_eq("satdn.count", 32'(cnt_s), 32'd4);
        chk_eq("satdn.sat",   32'(sat_s), 32'd0);

        // load clamp with en high, then reset beats load
        max_val = 4'd7; load_val = 4'd12; load = 1'b1; up_down = 1'b1;
        tick();
        chk_eq("clamp.count", 32'(cnt_w), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0;

        // run-time max shrink, up and down
        max_val = 4'd15; load_val = 4'd8; load = 1'b1;
        tick();
        load = 1'b0; max_val = 4'd3; up_down = 1'b1;
        tick();
        chk_eq("shrink.up_wrap", 32'(cnt_w), 32'd0);
        chk_eq("shrink.up_sat",  32'(cnt_s), 32'd3);
        max_val = 4'd15; load = 1'b1;
        tick();
        load = 1'b0; max_val = 4'd3; up_down = 1'b0;
        tick();
        chk_eq("shrink.dn", 32'(cnt_w), 32'd3);

        // enable hold, then max_val = 0
        en = 1'b0;
        repeat (5) tick();
        max_val = 4'd0; en = 1'b1; up_down = 1'b1;
        repeat (3) tick();
        up_down = 1'b0;
        repeat (2) tick();

        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(63) == 0);
            load     = ($urandom_range(7) == 0);
            en       = ($urandom_range(3) != 0);
            up_down  = $urandom_range(1);
            load_val = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) max_val = 4'($urandom_range(15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
